// File: rtl/pump_scheduler.sv
// Round-robin pump/valve sequencer: VALVE -> SERVE -> DRAIN per line; `FILL_PRIORITY_EN gives line 0 strict priority.
// Latency: all outputs registered; a grant shows one clk_fg edge after the request is sampled.
// Backpressure: none; lockout_i forces DRAIN on the next edge, waiting requests are held off until IDLE.
module pump_scheduler #(
    parameter int N_REQ        = 4,
    parameter int SPINUP_TICKS = 3,
    parameter int MIN_ON_TICKS = 8,
    parameter int MAX_ON_TICKS = 32,
    parameter int DEAD_TICKS   = 2
) (
    input  logic                     clk_fg,
    input  logic                     init_pulse,
    input  logic                     tick_i,
    input  logic [N_REQ-1:0]         req_i,
    input  logic                     lockout_i,
    output logic [N_REQ-1:0]         grant_o,
    output logic                     pump_on_o,
    output logic [$clog2(N_REQ)-1:0] active_id_o,
    output logic                     busy_o,
    output logic                     serve_done_o
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int LIM_A = (MAX_ON_TICKS > SPINUP_TICKS) ? MAX_ON_TICKS : SPINUP_TICKS;
    localparam int LIM   = (LIM_A > DEAD_TICKS) ? LIM_A : DEAD_TICKS;
    localparam int CNT_W = $clog2(LIM + 1);

    typedef enum logic [1:0] {IDLE, VALVE, SERVE, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    active_q, active_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               pump_q, pump_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [ID_W-1:0]    pick;
    logic               pick_vld;
    logic [N_REQ-1:0]   act_mask;
    logic               req_act;
    logic               others_pending;
    int                 rr_idx;

    // First requester strictly after the last-served line, wrapping around.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        rr_idx   = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            rr_idx = int'(last_q) + i;
            if (rr_idx >= N_REQ) rr_idx = rr_idx - N_REQ;
            if (!pick_vld && req_i[ID_W'(rr_idx)]) begin
                pick     = ID_W'(rr_idx);
                pick_vld = 1'b1;
            end
        end
`ifdef FILL_PRIORITY_EN
        if (req_i[0]) begin
            pick     = '0;
            pick_vld = 1'b1;
        end
`endif
    end

    always_comb begin
        act_mask = '0;
        for (int i = 0; i < N_REQ; i++) act_mask[i] = (active_q == ID_W'(i));
        req_act        = |(req_i & act_mask);
        others_pending = |(req_i & ~act_mask);
    end

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!lockout_i && pick_vld) begin
                    state_d  = VALVE;
                    active_d = pick;
                end
            end
            VALVE: begin
                if (lockout_i || !req_act) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(SPINUP_TICKS)) begin
                    state_d = SERVE;
                    cnt_d   = '0;
                end else if (tick_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SERVE: begin
                // Lockout outranks a simultaneous MAX_ON cut, so no done pulse then.
                if (lockout_i) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else if ((!req_act && cnt_q >= CNT_W'(MIN_ON_TICKS)) ||
                             (cnt_q == CNT_W'(MAX_ON_TICKS) && others_pending)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else if (tick_i && cnt_q != CNT_W'(MAX_ON_TICKS)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == CNT_W'(DEAD_TICKS)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
`ifdef FILL_PRIORITY_EN
                    if (active_q != '0) last_d = active_q;
`else
                    last_d = active_q;
`endif
                end else if (tick_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        grant_d = '0;
        for (int i = 0; i < N_REQ; i++) grant_d[i] = (state_d != IDLE) && (active_d == ID_W'(i));
        pump_d = (state_d == SERVE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_fg) begin
        if (init_pulse) begin
            state_q  <= IDLE;
            active_q <= '0;
            last_q   <= ID_W'(N_REQ - 1);
            cnt_q    <= '0;
            grant_q  <= '0;
            pump_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            pump_q   <= pump_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign grant_o      = grant_q;
    assign pump_on_o    = pump_q;
    assign active_id_o  = active_q;
    assign busy_o       = busy_q;
    assign serve_done_o = done_q;
endmodule
